dsp19x2_mac_sequencer: RTL and testbench
========================================

// Module: dsp19x2_mac_sequencer
// PURPOSE
//   Sequences one DSP19X2 in MULTIPLY_ACCUMULATE mode to compute two dot products per job: Z1=sum(A1*B1), Z2=sum(A2*B2).
//   Accepts a job command, then a stream of operand pairs. Drives LOAD_ACC, FEEDBACK and zero-bubbles.
//   Waits out the DSP pipeline, then returns both sums on a valid/ready result port.
//   Sits between a stream source and the DSP19X2 instance; owns every DSP control input.
// PARAMETERS
//   LEN_W    8  width of cmd_len; max job length 2**LEN_W-1 element pairs
//   DSP_LAT  2  cycles from DSP input to valid Z (2 = INPUT_REG_EN and OUTPUT_REG_EN TRUE); legal range 1..7
// PORTS
//   CLK            in   1      clock
//   RESET          in   1      synchronous, active-high reset
//   cmd_valid      in   1      job request
//   cmd_ready      out  1      job accepted; high only in IDLE
//   cmd_len        in   LEN_W  number of element pairs
//   cmd_cfg        in   9      {unsigned_a, unsigned_b, saturate, round, shift_right[4:0]}
//   in_valid       in   1      operand pair valid
//   in_ready       out  1      high only in ACCUM while elements remain
//   in_a1/in_a2    in   10     A operands
//   in_b1/in_b2    in   9      B operands
//   res_valid      out  1      result valid
//   res_ready      in   1      result accepted
//   res_z1/res_z2  out  19     captured sums
//   dsp_a1/dsp_a2  out  10     to DSP A1/A2
//   dsp_b1/dsp_b2  out  9      to DSP B1/B2
//   dsp_load_acc   out  1      to LOAD_ACC
//   dsp_feedback   out  3      to FEEDBACK; constant 3'b000
//   dsp_acc_fir    out  5      to ACC_FIR; constant 0
//   dsp_subtract   out  1      to SUBTRACT; constant 0
//   dsp_cfg        out  9      latched cmd_cfg: UNSIGNED_A, UNSIGNED_B, SATURATE, ROUND, SHIFT_RIGHT
//   dsp_reset      out  1      to DSP RESET; equals RESET, combinational
//   dsp_z1/dsp_z2  in   19     from DSP Z1/Z2
// BEHAVIOUR
//   Reset values: all outputs 0, state IDLE, counters 0.
//   FSM: IDLE -> ACCUM -> DRAIN -> DONE -> IDLE.
//   IDLE
//     - cmd_ready=1.
//     - On cmd_valid: latch cmd_len into remaining counter, cmd_cfg into dsp_cfg, set first=1.
//     - If cmd_len==0, go to DONE with res_z1=res_z2=0 and no DSP traffic.
//     - Otherwise go to ACCUM.
//   ACCUM, per cycle
//     - in_ready=1.
//     - On in_valid: register operands to dsp_a*/dsp_b*; dsp_load_acc=first; clear first; remaining--.
//     - On !in_valid (bubble): dsp_a*=dsp_b*=0, dsp_load_acc=0, so the accumulator holds its value.
//     - When the last element transfers, go to DRAIN and load drain counter = DSP_LAT.
//   DRAIN
//     - dsp_a*/dsp_b*=0, load_acc=0.
//     - Counter decrements each cycle; at 0, capture dsp_z1/dsp_z2 into res_z1/res_z2 and go to DONE.
//   DONE
//     - res_valid=1; res_z* stable until res_ready; then go to IDLE with res_valid=0.
//     - res_ready while res_valid=0 is ignored.
//   DSP operand outputs are registered. DSP sees element k one cycle after its handshake.
//   Result timing: last handshake at cycle t -> res_valid high at cycle t+DSP_LAT+2.
//   cmd_cfg is stable in dsp_cfg for the whole job, including DRAIN.
//   Arithmetic (accumulation, saturation, shift, round) is done by the DSP. The sequencer does no math.
//   A 1-element job is legal: load_acc=1 on that element only.
//   Reset mid-job: next cycle state is IDLE, the partial result is discarded, and the DSP is reset via dsp_reset.
//   No cmd acceptance outside IDLE; cmd_valid held high waits.
// TESTING (bench instantiates DSP19X2, MULTIPLY_ACCUMULATE, both regs TRUE, DSP_LAT=2)
//   1. len=3, cfg=0, A1={3,-2,5} B1={4,7,-1}, A2={1,1,1} B2={10,20,30}, no bubbles
//      -> res_z1=-7, res_z2=60; res_valid 4 cycles after the last handshake.
//   2. Same data with in_valid low for 2 cycles between each element -> same results; dsp_load_acc high exactly once.
//   3. Result backpressure: res_ready low 5 cycles -> res_valid and res_z* held; cmd_ready stays 0 until accept.
//   4. len=0 -> res_valid one cycle after accept, res_z1=res_z2=0, dsp_load_acc never asserted.
//   5. RESET during ACCUM after 2 of 4 elements -> all outputs 0 next cycle; new len=1 job 2*3 -> res_z1=6.
//   6. Back-to-back jobs len=2 then len=1
//      -> second job's load_acc discards the first sum; results {1*1+2*2=5} then {7*3=21} on Z1.

Source files
------------

// File: rtl/dsp19x2_mac_sequencer.sv
// dsp19x2_mac_sequencer
// Drives a single DSP19X2 in multiply-accumulate mode to compute two dot
// products per job (Z1 = sum A1*B1, Z2 = sum A2*B2). A job command is taken
// in IDLE, operand pairs are streamed to the DSP in ACCUM (bubbles hold the
// accumulator), DRAIN waits out the DSP pipeline, and DONE presents both sums
// on a valid/ready result port. All DSP control inputs are owned here; the
// sequencer itself does no arithmetic.
// DSP_LAT must lie in 1..7 (the drain counter is 3 bits wide).

module dsp19x2_mac_sequencer #(
   parameter int LEN_W   = 8,
   parameter int DSP_LAT = 2
) (
   input  logic             i_clk,
   input  logic             i_reset,
   // job command
   input  logic             i_cmd_valid,
   output logic             o_cmd_ready,
   input  logic [LEN_W-1:0] i_cmd_len,
   input  logic [8:0]       i_cmd_cfg,
   // operand stream
   input  logic             i_in_valid,
   output logic             o_in_ready,
   input  logic [9:0]       i_in_a1,
   input  logic [9:0]       i_in_a2,
   input  logic [8:0]       i_in_b1,
   input  logic [8:0]       i_in_b2,
   // result
   output logic             o_res_valid,
   input  logic             i_res_ready,
   output logic [18:0]      o_res_z1,
   output logic [18:0]      o_res_z2,
   // DSP19X2 control and data
   output logic [9:0]       o_dsp_a1,
   output logic [9:0]       o_dsp_a2,
   output logic [8:0]       o_dsp_b1,
   output logic [8:0]       o_dsp_b2,
   output logic             o_dsp_load_acc,
   output logic [2:0]       o_dsp_feedback,
   output logic [4:0]       o_dsp_acc_fir,
   output logic             o_dsp_subtract,
   output logic [8:0]       o_dsp_cfg,
   output logic             o_dsp_reset,
   input  logic [18:0]      i_dsp_z1,
   input  logic [18:0]      i_dsp_z2
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam logic [2:0]       LP_DRAIN_INIT = 3'(DSP_LAT);
   localparam logic [LEN_W-1:0] LP_LEN_ONE    = LEN_W'(1);

   // state and registered outputs
   state_t             r_state;
   logic [LEN_W-1:0]   r_remaining;
   logic               r_first;
   logic [2:0]         r_drain;
   logic [8:0]         r_cfg;
   logic               r_cmd_ready;
   logic               r_in_ready;
   logic               r_res_valid;
   logic [18:0]        r_res_z1;
   logic [18:0]        r_res_z2;
   logic [9:0]         r_dsp_a1;
   logic [9:0]         r_dsp_a2;
   logic [8:0]         r_dsp_b1;
   logic [8:0]         r_dsp_b2;
   logic               r_dsp_load_acc;

   // next-state values
   state_t             w_state_nxt;
   logic [LEN_W-1:0]   w_remaining_nxt;
   logic               w_first_nxt;
   logic [2:0]         w_drain_nxt;
   logic [8:0]         w_cfg_nxt;
   logic [18:0]        w_res_z1_nxt;
   logic [18:0]        w_res_z2_nxt;
   logic [9:0]         w_dsp_a1_nxt;
   logic [9:0]         w_dsp_a2_nxt;
   logic [8:0]         w_dsp_b1_nxt;
   logic [8:0]         w_dsp_b2_nxt;
   logic               w_dsp_load_acc_nxt;

   // handshakes use the registered ready flags the source actually sees
   logic               w_cmd_fire;
   logic               w_in_fire;
   logic               w_res_fire;

   assign w_cmd_fire = i_cmd_valid & r_cmd_ready;
   assign w_in_fire  = i_in_valid  & r_in_ready;
   assign w_res_fire = i_res_ready & r_res_valid;

   // Next-state, operand steering and result capture for the job sequence.
   always_comb begin
      w_state_nxt        = r_state;
      w_remaining_nxt    = r_remaining;
      w_first_nxt        = r_first;
      w_drain_nxt        = r_drain;
      w_cfg_nxt          = r_cfg;
      w_res_z1_nxt       = r_res_z1;
      w_res_z2_nxt       = r_res_z2;
      // zero operands with load_acc low make the DSP hold its accumulator
      w_dsp_a1_nxt       = 10'd0;
      w_dsp_a2_nxt       = 10'd0;
      w_dsp_b1_nxt       = 9'd0;
      w_dsp_b2_nxt       = 9'd0;
      w_dsp_load_acc_nxt = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (w_cmd_fire) begin
               w_remaining_nxt = i_cmd_len;
               w_cfg_nxt       = i_cmd_cfg;
               w_first_nxt     = 1'b1;
               if (i_cmd_len == '0) begin
                  // empty job: report zero sums without touching the DSP
                  w_state_nxt  = ST_DONE;
                  w_res_z1_nxt = 19'd0;
                  w_res_z2_nxt = 19'd0;
               end else begin
                  w_state_nxt  = ST_ACCUM;
               end
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end

         ST_ACCUM: begin
            if (w_in_fire) begin
               w_dsp_a1_nxt       = i_in_a1;
               w_dsp_a2_nxt       = i_in_a2;
               w_dsp_b1_nxt       = i_in_b1;
               w_dsp_b2_nxt       = i_in_b2;
               // first element overwrites the accumulator, discarding any old sum
               w_dsp_load_acc_nxt = r_first;
               w_first_nxt        = 1'b0;
               w_remaining_nxt    = r_remaining - LP_LEN_ONE;
               if (r_remaining <= LP_LEN_ONE) begin
                  w_state_nxt = ST_DRAIN;
                  w_drain_nxt = LP_DRAIN_INIT;
               end else begin
                  w_state_nxt = ST_ACCUM;
               end
            end else begin
               w_state_nxt = ST_ACCUM;
            end
         end

         ST_DRAIN: begin
            if (r_drain == 3'd0) begin
               // last element has now propagated through the DSP pipeline
               w_res_z1_nxt = i_dsp_z1;
               w_res_z2_nxt = i_dsp_z2;
               w_state_nxt  = ST_DONE;
            end else begin
               w_drain_nxt  = r_drain - 3'd1;
               w_state_nxt  = ST_DRAIN;
            end
         end

         ST_DONE: begin
            if (w_res_fire) begin
               w_state_nxt = ST_IDLE;
            end else begin
               w_state_nxt = ST_DONE;
            end
         end

         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // FSM state register.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Job counters, latched configuration and captured result.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_remaining <= '0;
         r_first     <= 1'b0;
         r_drain     <= 3'd0;
         r_cfg       <= 9'd0;
         r_res_z1    <= 19'd0;
         r_res_z2    <= 19'd0;
      end else begin
         r_remaining <= w_remaining_nxt;
         r_first     <= w_first_nxt;
         r_drain     <= w_drain_nxt;
         r_cfg       <= w_cfg_nxt;
         r_res_z1    <= w_res_z1_nxt;
         r_res_z2    <= w_res_z2_nxt;
      end
   end

   // Registered DSP operand and LOAD_ACC drive.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_dsp_a1       <= 10'd0;
         r_dsp_a2       <= 10'd0;
         r_dsp_b1       <= 9'd0;
         r_dsp_b2       <= 9'd0;
         r_dsp_load_acc <= 1'b0;
      end else begin
         r_dsp_a1       <= w_dsp_a1_nxt;
         r_dsp_a2       <= w_dsp_a2_nxt;
         r_dsp_b1       <= w_dsp_b1_nxt;
         r_dsp_b2       <= w_dsp_b2_nxt;
         r_dsp_load_acc <= w_dsp_load_acc_nxt;
      end
   end

   // Handshake flags registered from the next state so every port is a flop;
   // they read 0 for the cycle right after reset.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_cmd_ready <= 1'b0;
         r_in_ready  <= 1'b0;
         r_res_valid <= 1'b0;
      end else begin
         r_cmd_ready <= (w_state_nxt == ST_IDLE);
         r_in_ready  <= (w_state_nxt == ST_ACCUM);
         r_res_valid <= (w_state_nxt == ST_DONE);
      end
   end

   assign o_cmd_ready    = r_cmd_ready;
   assign o_in_ready     = r_in_ready;
   assign o_res_valid    = r_res_valid;
   assign o_res_z1       = r_res_z1;
   assign o_res_z2       = r_res_z2;
   assign o_dsp_a1       = r_dsp_a1;
   assign o_dsp_a2       = r_dsp_a2;
   assign o_dsp_b1       = r_dsp_b1;
   assign o_dsp_b2       = r_dsp_b2;
   assign o_dsp_load_acc = r_dsp_load_acc;
   assign o_dsp_cfg      = r_cfg;
   // fixed DSP modes: plain accumulate, no FIR shift, no subtraction
   assign o_dsp_feedback = 3'b000;
   assign o_dsp_acc_fir  = 5'd0;
   assign o_dsp_subtract = 1'b0;
   // the DSP is reset together with the sequencer so a partial sum is dropped
   assign o_dsp_reset    = i_reset;

endmodule

// File: tb/tb_dsp19x2_mac_sequencer.sv
// Directed bench for dsp19x2_mac_sequencer with a behavioural stand-in for a
// DSP19X2 in multiply-accumulate mode (input and output registers enabled,
// so DSP_LAT = 2). Expected sums are hand-computed constants.

module tb_dsp19x2_mac_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid, cmd_ready;
   logic [7:0]  cmd_len;
   logic [8:0]  cmd_cfg;
   logic        in_valid, in_ready;
   logic [9:0]  in_a1, in_a2;
   logic [8:0]  in_b1, in_b2;
   logic        res_valid, res_ready;
   logic [18:0] res_z1, res_z2;
   logic [9:0]  dsp_a1, dsp_a2;
   logic [8:0]  dsp_b1, dsp_b2;
   logic        dsp_load_acc;
   logic [2:0]  dsp_feedback;
   logic [4:0]  dsp_acc_fir;
   logic        dsp_subtract;
   logic [8:0]  dsp_cfg;
   logic        dsp_reset;
   logic [18:0] dsp_z1, dsp_z2;

   int n_chk  = 0;
   int n_pass = 0;
   int n_fail = 0;
   int cyc    = 0;
   int la_cnt = 0;

   always #5 clk = ~clk;

   dsp19x2_mac_sequencer #(.LEN_W(8), .DSP_LAT(2)) dut (
      .i_clk(clk), .i_reset(rst),
      .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
      .i_cmd_len(cmd_len), .i_cmd_cfg(cmd_cfg),
      .i_in_valid(in_valid), .o_in_ready(in_ready),
      .i_in_a1(in_a1), .i_in_a2(in_a2), .i_in_b1(in_b1), .i_in_b2(in_b2),
      .o_res_valid(res_valid), .i_res_ready(res_ready),
      .o_res_z1(res_z1), .o_res_z2(res_z2),
      .o_dsp_a1(dsp_a1), .o_dsp_a2(dsp_a2), .o_dsp_b1(dsp_b1), .o_dsp_b2(dsp_b2),
      .o_dsp_load_acc(dsp_load_acc), .o_dsp_feedback(dsp_feedback),
      .o_dsp_acc_fir(dsp_acc_fir), .o_dsp_subtract(dsp_subtract),
      .o_dsp_cfg(dsp_cfg), .o_dsp_reset(dsp_reset),
      .i_dsp_z1(dsp_z1), .i_dsp_z2(dsp_z2)
   );

   // DSP19X2 stand-in: input register stage, then accumulator/output register
   logic signed [9:0]  m_a1, m_a2;
   logic signed [8:0]  m_b1, m_b2;
   logic               m_ld;
   logic signed [18:0] m_z1, m_z2;
   logic signed [18:0] m_p1, m_p2;
   assign m_p1   = 19'(m_a1 * m_b1);
   assign m_p2   = 19'(m_a2 * m_b2);
   assign dsp_z1 = m_z1;
   assign dsp_z2 = m_z2;

   always @(posedge clk) begin
      if (dsp_reset) begin
         m_a1 <= 10'sd0; m_a2 <= 10'sd0; m_b1 <= 9'sd0; m_b2 <= 9'sd0;
         m_ld <= 1'b0;   m_z1 <= 19'sd0; m_z2 <= 19'sd0;
      end else begin
         m_a1 <= dsp_a1; m_a2 <= dsp_a2; m_b1 <= dsp_b1; m_b2 <= dsp_b2;
         m_ld <= dsp_load_acc;
         m_z1 <= m_ld ? m_p1 : m_z1 + m_p1;
         m_z2 <= m_ld ? m_p2 : m_z2 + m_p2;
      end
   end

   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) if (dsp_load_acc) la_cnt <= la_cnt + 1;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // all stimulus tasks start and end 1 time unit after a rising edge
   task automatic send_cmd(input logic [7:0] len, input logic [8:0] cfg, output int t_acc);
      bit got = 1'b0;
      t_acc = -1;
      cmd_valid = 1'b1; cmd_len = len; cmd_cfg = cfg;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         if (cmd_ready) begin got = 1'b1; t_acc = cyc; end
         @(posedge clk); #1;
      end
      cmd_valid = 1'b0;
      chk("cmd_accept", 32'(got), 32'd1);
   endtask

   task automatic send_elem(input logic [9:0] a1, input logic [8:0] b1,
                            input logic [9:0] a2, input logic [8:0] b2, output int t_hs);
      bit got = 1'b0;
      t_hs = -1;
      in_valid = 1'b1; in_a1 = a1; in_b1 = b1; in_a2 = a2; in_b2 = b2;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         if (in_ready) begin got = 1'b1; t_hs = cyc; end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      chk("elem_accept", 32'(got), 32'd1);
   endtask

   // returns at the falling edge where res_valid is first seen
   task automatic wait_valid(output int t_res);
      bit got = 1'b0;
      t_res = -1;
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clk);
         if (res_valid) begin got = 1'b1; t_res = cyc; end
      end
      chk("res_valid_timeout", 32'(got), 32'd1);
   endtask

   // called at a falling edge with res_valid high
   task automatic accept_result();
      res_ready = 1'b1;
      @(posedge clk); #1;
      res_ready = 1'b0;
      @(negedge clk);
      chk("res_valid_drop", 32'(res_valid), 32'd0);
      @(posedge clk); #1;
   endtask

   initial begin
      int t_acc, t_hs, t_res, la0;
      rst = 1'b1; cmd_valid = 1'b0; cmd_len = 8'd0; cmd_cfg = 9'd0;
      in_valid = 1'b0; in_a1 = 10'd0; in_a2 = 10'd0; in_b1 = 9'd0; in_b2 = 9'd0;
      res_ready = 1'b0;

      // reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
      chk("rst_in_ready",  32'(in_ready),  32'd0);
      chk("rst_res_valid", 32'(res_valid), 32'd0);
      chk("rst_res_z1",    32'(res_z1),    32'd0);
      chk("rst_dsp_cfg",   32'(dsp_cfg),   32'd0);
      chk("rst_dsp_reset", 32'(dsp_reset), 32'd1);
      @(posedge clk); #1;
      rst = 1'b0;

      // 1: len=3 no bubbles -> Z1=-7, Z2=60, result 4 cycles after last handshake
      la0 = la_cnt;
      send_cmd(8'd3, 9'd0, t_acc);
      send_elem( 10'sd3,  9'sd4, 10'sd1, 9'sd10, t_hs);
      send_elem(-10'sd2,  9'sd7, 10'sd1, 9'sd20, t_hs);
      send_elem( 10'sd5, -9'sd1, 10'sd1, 9'sd30, t_hs);
      wait_valid(t_res);
      chk("t1_latency", 32'(t_res - t_hs), 32'd4);
      chk("t1_z1", 32'(res_z1), 32'h7FFF9);
      chk("t1_z2", 32'(res_z2), 32'd60);
      chk("t1_load_once", 32'(la_cnt - la0), 32'd1);
      chk("t1_feedback", {27'd0, dsp_subtract, dsp_acc_fir, dsp_feedback}, 32'd0);
      accept_result();

      // 2: same data with two bubble cycles between elements
      la0 = la_cnt;
      send_cmd(8'd3, 9'd0, t_acc);
      send_elem(10'sd3, 9'sd4, 10'sd1, 9'sd10, t_hs);
      @(negedge clk);
      chk("t2_dsp_a1_first", 32'(dsp_a1), 32'd3);
      chk("t2_dsp_b2_first", 32'(dsp_b2), 32'd10);
      chk("t2_load_first", 32'(dsp_load_acc), 32'd1);
      @(posedge clk); #1;
      @(negedge clk);
      chk("t2_bubble_a1", 32'(dsp_a1), 32'd0);
      chk("t2_bubble_load", 32'(dsp_load_acc), 32'd0);
      @(posedge clk); #1;
      send_elem(-10'sd2, 9'sd7, 10'sd1, 9'sd20, t_hs);
      @(negedge clk);
      chk("t2_dsp_a1_second", 32'(dsp_a1), 32'h3FE);
      chk("t2_load_second", 32'(dsp_load_acc), 32'd0);
      @(posedge clk); #1;
      repeat (1) @(posedge clk); #1;
      send_elem(10'sd5, -9'sd1, 10'sd1, 9'sd30, t_hs);
      wait_valid(t_res);
      chk("t2_latency", 32'(t_res - t_hs), 32'd4);
      chk("t2_z1", 32'(res_z1), 32'h7FFF9);
      chk("t2_z2", 32'(res_z2), 32'd60);
      chk("t2_load_once", 32'(la_cnt - la0), 32'd1);
      accept_result();

      // 3: backpressure, len=2 -> Z1=2*4+3*5=23, Z2=-6-6=-12; cmd_valid waits
      send_cmd(8'd2, 9'd0, t_acc);
      send_elem(10'sd2, 9'sd4, -10'sd1, 9'sd6, t_hs);
      send_elem(10'sd3, 9'sd5, -10'sd1, 9'sd6, t_hs);
      wait_valid(t_res);
      cmd_valid = 1'b1; cmd_len = 8'd0; cmd_cfg = 9'd0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("t3_hold_valid", 32'(res_valid), 32'd1);
         chk("t3_hold_z1", 32'(res_z1), 32'd23);
         chk("t3_hold_z2", 32'(res_z2), 32'h7FFF4);
         chk("t3_cmd_ready_low", 32'(cmd_ready), 32'd0);
      end
      // 4: queued len=0 job is accepted only once the result is taken
      la0 = la_cnt;
      res_ready = 1'b1;
      @(posedge clk); #1;
      res_ready = 1'b0;
      @(negedge clk);
      chk("t3_res_valid_drop", 32'(res_valid), 32'd0);
      chk("t4_cmd_ready", 32'(cmd_ready), 32'd1);
      t_acc = cyc;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      wait_valid(t_res);
      chk("t4_latency", 32'(t_res - t_acc), 32'd1);
      chk("t4_z1", 32'(res_z1), 32'd0);
      chk("t4_z2", 32'(res_z2), 32'd0);
      chk("t4_no_load", 32'(la_cnt - la0), 32'd0);
      accept_result();

      // 5: reset after 2 of 4 elements, then len=1 job 2*3=6, 4*-5=-20
      send_cmd(8'd4, 9'h045, t_acc);
      send_elem(10'sd9, 9'sd9, 10'sd9, 9'sd9, t_hs);
      send_elem(10'sd8, 9'sd8, 10'sd8, 9'sd8, t_hs);
      @(negedge clk);
      chk("t5_cfg_latched", 32'(dsp_cfg), 32'h045);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("t5_rst_cmd_ready", 32'(cmd_ready), 32'd0);
      chk("t5_rst_in_ready", 32'(in_ready), 32'd0);
      chk("t5_rst_res_valid", 32'(res_valid), 32'd0);
      chk("t5_rst_dsp_a1", 32'(dsp_a1), 32'd0);
      chk("t5_rst_load", 32'(dsp_load_acc), 32'd0);
      chk("t5_rst_cfg", 32'(dsp_cfg), 32'd0);
      chk("t5_rst_dsp_reset", 32'(dsp_reset), 32'd0);
      @(posedge clk); #1;
      send_cmd(8'd1, 9'd0, t_acc);
      send_elem(10'sd2, 9'sd3, 10'sd4, -9'sd5, t_hs);
      wait_valid(t_res);
      chk("t5_latency", 32'(t_res - t_hs), 32'd4);
      chk("t5_z1", 32'(res_z1), 32'd6);
      chk("t5_z2", 32'(res_z2), 32'h7FFEC);
      accept_result();

      // 6: back-to-back jobs; second load_acc discards the first sum
      send_cmd(8'd2, 9'd0, t_acc);
      send_elem(10'sd1, 9'sd1, 10'sd0, 9'sd0, t_hs);
      send_elem(10'sd2, 9'sd2, 10'sd3, 9'sd3, t_hs);
      wait_valid(t_res);
      chk("t6a_z1", 32'(res_z1), 32'd5);
      chk("t6a_z2", 32'(res_z2), 32'd9);
      accept_result();
      la0 = la_cnt;
      send_cmd(8'd1, 9'd0, t_acc);
      send_elem(10'sd7, 9'sd3, -10'sd1, -9'sd1, t_hs);
      wait_valid(t_res);
      chk("t6b_z1", 32'(res_z1), 32'd21);
      chk("t6b_z2", 32'(res_z2), 32'd1);
      chk("t6b_load_once", 32'(la_cnt - la0), 32'd1);
      accept_result();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
